// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op codes and FSM encoding shared by the multiply/divide unit
package mdu_pkg;

  localparam logic [1:0] OP_DIVU = 2'd0;
  localparam logic [1:0] OP_DIV  = 2'd1;
  localparam logic [1:0] OP_MTHI = 2'd2;
  localparam logic [1:0] OP_MTLO = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_RUN,
    S_DONE
  } state_t;

endpackage

// File: rtl/div_hilo_sequencer.sv
// rtl/div_hilo_sequencer.sv - DIV/DIVU/MTHI/MTLO sequencer owning HI/LO and driving the iterative divider
module div_hilo_sequencer
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MAX_CYCLES = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             stall,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_err,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_busy,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r
);

  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(MAX_CYCLES - 1);

  state_t        state;
  logic          wait_seen;
  logic [CW-1:0] wd_cnt;
  logic          is_div;
  logic          accept;

  assign is_div = op_valid && (op_code == OP_DIVU || op_code == OP_DIV);
  assign accept = (state == S_IDLE) && is_div && (rt_data != '0);

  // Low in DONE so the CPU advances on the same edge that writes HI/LO.
  assign stall = accept || (state == S_START) || (state == S_WAIT_BUSY) || (state == S_RUN);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= S_IDLE;
      hi_out       <= '0;
      lo_out       <= '0;
      div_err      <= 1'b0;
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      wait_seen    <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      div_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            div_dividend <= rs_data;
            div_divisor  <= rt_data;
            div_start    <= 1'b1;
            state        <= S_START;
          end else if (op_valid) begin
            case (op_code)
              OP_MTHI: hi_out <= rs_data;
              OP_MTLO: lo_out <= rs_data;
              default: begin
                // divide by zero: defined result without running the divider
                hi_out <= rs_data;
                lo_out <= '1;
              end
            endcase
          end
        end
        S_START: begin
          wd_cnt    <= '0;
          wait_seen <= 1'b0;
          state     <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (wd_cnt == WD_LAST) begin
            div_err <= 1'b1;
            state   <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            // a very short run may finish before busy is ever seen
            if (div_busy || wait_seen) state <= S_RUN;
            else wait_seen <= 1'b1;
          end
        end
        S_RUN: begin
          if (wd_cnt == WD_LAST) begin
            div_err <= 1'b1;
            state   <= S_IDLE;
          end else if (!div_busy) begin
            state <= S_DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_DONE: begin
          hi_out <= div_r;
          lo_out <= div_q;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_hilo_sequencer.sv
// tb/tb_div_hilo_sequencer.sv - self-checking bench for div_hilo_sequencer with a behavioural divider
module tb_div_hilo_sequencer;
  import mdu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        stall, div_err, div_start;
  logic [31:0] hi_out, lo_out, div_dividend, div_divisor;
  logic        div_busy = 1'b0;
  logic [31:0] div_q = '0;
  logic [31:0] div_r = '0;

  int vectors = 0;
  int errors  = 0;
  int start_cnt = 0;
  bit cur_signed = 1'b0;
  bit stuck = 1'b0;
  int busy_left = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  div_hilo_sequencer #(.WIDTH(32), .MAX_CYCLES(40)) dut (
    .clock(clock), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .rs_data(rs_data), .rt_data(rt_data), .stall(stall), .hi_out(hi_out),
    .lo_out(lo_out), .div_err(div_err), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_busy(div_busy),
    .div_q(div_q), .div_r(div_r)
  );

  always #5 clock = ~clock;

  // truncating division, remainder takes the dividend's sign; returns {rem, quot}
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    if (sgn) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'h0, a});
      lb = longint'({32'h0, b});
    end
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  // behavioural divider: 32 busy cycles after a start pulse
  always @(posedge clock) begin
    if (div_start) start_cnt <= start_cnt + 1;
    if (!reset) begin
      div_busy  <= 1'b0;
      busy_left <= 0;
    end else if (div_start) begin
      div_busy  <= 1'b1;
      busy_left <= 32;
      {div_r, div_q} <= ref_div(cur_signed, div_dividend, div_divisor);
    end else if (div_busy && !stuck) begin
      if (busy_left == 1) div_busy <= 1'b0;
      else busy_left <= busy_left - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // issue one instruction, holding it while stalled; returns at the negedge after the advancing edge
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int stall_cyc, output int starts, output bit timeout);
    int n;
    @(negedge clock);
    start_cnt  = 0;
    op_valid   = 1'b1;
    op_code    = op;
    rs_data    = a;
    rt_data    = b;
    cur_signed = (op == OP_DIV);
    stall_cyc  = 0;
    n = 0;
    #1;
    while (stall && n < 200) begin
      stall_cyc++;
      @(negedge clock);
      #1;
      n++;
    end
    timeout = (n >= 200);
    @(posedge clock);
    @(negedge clock);
    op_valid = 1'b0;
    starts = start_cnt;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_starts;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int sc, st, n;
    bit to;
    logic [1:0] op;
    logic [31:0] a, b;
    logic [63:0] rq;

    tbl[0] = '{OP_DIVU, 32'd100,        32'd7,        32'd2,        32'd14,       1};
    tbl[1] = '{OP_DIV,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1};
    tbl[2] = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1};
    tbl[3] = '{OP_DIVU, 32'd5,          32'd0,        32'd5,        32'hFFFFFFFF, 0};
    tbl[4] = '{OP_MTHI, 32'hDEADBEEF,   32'd0,        32'hDEADBEEF, 32'hFFFFFFFF, 0};
    tbl[5] = '{OP_MTLO, 32'h12345678,   32'd0,        32'hDEADBEEF, 32'h12345678, 0};
    tbl[6] = '{OP_DIVU, 32'hFFFFFFFF,   32'd2,        32'd1,        32'h7FFFFFFF, 1};
    tbl[7] = '{OP_DIV,  32'd7,          32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1};
    tbl[8] = '{OP_DIV,  32'hFFFFFFF9,   32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        1};

    // reset held two cycles
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_err", {31'd0, div_err}, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_stall", {31'd0, stall}, 32'd0);
    chk("idle_start", {31'd0, div_start}, 32'd0);

    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].rs, tbl[i].rt, sc, st, to);
      chk($sformatf("v%0d_timeout", i), {31'd0, to}, 32'd0);
      chk($sformatf("v%0d_hi", i), hi_out, tbl[i].exp_hi);
      chk($sformatf("v%0d_lo", i), lo_out, tbl[i].exp_lo);
      chk($sformatf("v%0d_starts", i), st, tbl[i].exp_starts);
      chk($sformatf("v%0d_stall_len", i), sc, (tbl[i].exp_starts != 0) ? 35 : 0);
      model_hi = tbl[i].exp_hi;
      model_lo = tbl[i].exp_lo;
    end

    // MTHI presented while a DIV is running must be ignored
    @(negedge clock);
    start_cnt = 0;
    op_valid = 1'b1; op_code = OP_DIV; rs_data = 32'hFFFFFFF9; rt_data = 32'd2; cur_signed = 1'b1;
    repeat (5) @(negedge clock);
    op_code = OP_MTHI; rs_data = 32'hAAAA5555;
    n = 0;
    #1;
    while (stall && n < 200) begin @(negedge clock); #1; n++; end
    chk("mthi_run_timeout", {31'd0, n >= 200}, 32'd0);
    op_valid = 1'b0;
    @(negedge clock);
    chk("mthi_run_hi", hi_out, 32'hFFFFFFFF);
    chk("mthi_run_lo", lo_out, 32'hFFFFFFFD);
    chk("mthi_run_starts", start_cnt, 1);
    model_hi = 32'hFFFFFFFF;
    model_lo = 32'hFFFFFFFD;

    // randomized ops against the reference model
    for (int k = 0; k < 30; k++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (op == OP_DIV && $urandom_range(0, 3) == 0) b = 32'($signed(-$urandom_range(1, 9)));
      issue(op, a, b, sc, st, to);
      if (op == OP_MTHI) model_hi = a;
      else if (op == OP_MTLO) model_lo = a;
      else if (b == 0) begin model_hi = a; model_lo = '1; end
      else begin
        rq = ref_div(op == OP_DIV, a, b);
        model_hi = rq[63:32];
        model_lo = rq[31:0];
      end
      chk($sformatf("rnd%0d_hi", k), hi_out, model_hi);
      chk($sformatf("rnd%0d_lo", k), lo_out, model_lo);
      chk($sformatf("rnd%0d_starts", k), st, (op[1] == 1'b0 && b != 0) ? 1 : 0);
    end
    chk("err_clear", {31'd0, div_err}, 32'd0);

    // reset mid-run: division abandoned, HI/LO hold reset values
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    op_valid = 1'b1; op_code = OP_DIVU; rs_data = 32'd1000; rt_data = 32'd3; cur_signed = 1'b0;
    repeat (13) @(negedge clock);
    op_valid = 1'b0;
    chk("midrun_stall", {31'd0, stall}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("midrun_stall_after", {31'd0, stall}, 32'd0);
    repeat (40) @(negedge clock);
    chk("midrun_hi", hi_out, 32'd0);
    chk("midrun_lo", lo_out, 32'd0);
    chk("midrun_stall_late", {31'd0, stall}, 32'd0);

    // busy stuck high: watchdog fires, stall drops, HI/LO untouched
    stuck = 1'b1;
    @(negedge clock);
    op_valid = 1'b1; op_code = OP_DIVU; rs_data = 32'd9; rt_data = 32'd3; cur_signed = 1'b0;
    sc = 0; n = 0;
    #1;
    while (stall && n < 200) begin
      sc++;
      @(negedge clock);
      op_valid = 1'b0;
      #1;
      n++;
    end
    chk("wd_timeout", {31'd0, n >= 200}, 32'd0);
    chk("wd_stall_len", sc, 42);
    chk("wd_err", {31'd0, div_err}, 32'd1);
    chk("wd_hi", hi_out, 32'd0);
    chk("wd_lo", lo_out, 32'd0);
    issue(OP_MTHI, 32'h0BADF00D, 32'd0, sc, st, to);
    chk("wd_err_sticky", {31'd0, div_err}, 32'd1);
    chk("wd_mthi_after", hi_out, 32'h0BADF00D);
    stuck = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("wd_err_reset", {31'd0, div_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
